// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered-mux datapath blocks.
package mux_pkg;

  localparam int MUX_MAX_INPUTS = 64;

  // Number of bits needed to index n items; never less than 1.
  function automatic int clog2w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// One pipeline slot: W-bit register with asynchronous reset and load enable.
module pipe_reg_en #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] reg_d;
  logic [W-1:0] reg_q;

  always_comb begin
    reg_d = en ? d : reg_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) reg_q <= '0;
    else       reg_q <= reg_d;
  end

  assign q = reg_q;

endmodule

// File: rtl/mux_reg_pipe.sv
// N-way registered multiplexer feeding a STAGES-deep pipeline of {valid, data} slots,
// with a sticky flag for out-of-range selects on valid samples.
module mux_reg_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int INPUTS = 2,
  parameter  int STAGES = 1,
  localparam int SELW   = clog2w(INPUTS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [SELW-1:0]         sel,
  input  logic [INPUTS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        y,
  output logic                    out_valid,
  output logic                    sel_err
);

  if (STAGES < 1) begin : g_bad_stages
    $error("mux_reg_pipe: STAGES must be at least 1");
  end
  if (INPUTS < 2 || INPUTS > MUX_MAX_INPUTS) begin : g_bad_inputs
    $error("mux_reg_pipe: INPUTS must be in 2..MUX_MAX_INPUTS");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("mux_reg_pipe: WIDTH must be at least 1");
  end

  // Flow contract: in_valid qualifies sel/data only on an edge with en=1; out_valid
  // qualifies y. There is no ready; the upstream block throttles purely through en.

  logic [WIDTH-1:0] word_sel;
  logic             sel_hit;
  logic             sel_err_d;
  logic             sel_err_q;
  logic [WIDTH:0]   stage_d [STAGES];
  logic [WIDTH:0]   stage_q [STAGES];

  // An out-of-range select matches no word, so the sample is zero-filled.
  always_comb begin
    word_sel = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < INPUTS; k++) begin
      if (sel == SELW'(k)) begin
        word_sel = data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_err_d = sel_err_q | (en & in_valid & ~sel_hit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stage_d[g] = {in_valid, word_sel};
    end else begin : g_body
      assign stage_d[g] = stage_q[g-1];
    end

    pipe_reg_en #(.W(WIDTH + 1)) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .d     (stage_d[g]),
      .q     (stage_q[g])
    );
  end

  assign y         = stage_q[STAGES-1][WIDTH-1:0];
  assign out_valid = stage_q[STAGES-1][WIDTH];
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_reg_pipe.sv
// Bench for mux_reg_pipe: a 3-input, 3-stage instance under random stimulus against a
// delay-line reference model, plus the legacy 2:1 single-bit configuration.
module tb_mux_reg_pipe;

  localparam int W = 8;
  localparam int N = 3;
  localparam int S = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- main DUT ----------------
  logic           en       = 1'b0;
  logic           in_valid = 1'b0;
  logic [1:0]     sel      = '0;
  logic [N*W-1:0] data     = '0;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           sel_err;

  mux_reg_pipe #(.WIDTH(W), .INPUTS(N), .STAGES(S)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .sel       (sel),
    .data      (data),
    .y         (y),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

  // ---------------- legacy 2:1 DUT ----------------
  logic       lg_en       = 1'b1;
  logic       lg_in_valid = 1'b1;
  logic [0:0] lg_cond     = '0;
  logic [1:0] lg_data     = '0;
  logic [0:0] lg_y;
  logic       lg_out_valid;
  logic       lg_sel_err;

  mux_reg_pipe #(.WIDTH(1), .INPUTS(2), .STAGES(1)) dut_legacy (
    .clock     (clock),
    .reset     (reset),
    .en        (lg_en),
    .in_valid  (lg_in_valid),
    .sel       (lg_cond),
    .data      (lg_data),
    .y         (lg_y),
    .out_valid (lg_out_valid),
    .sel_err   (lg_sel_err)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];   // {valid, word} per slot, oldest (the output) at index 0
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < S; i++) exp_q.push_back('0);
    exp_err = 1'b0;
  endtask

  // Reference: each enabled edge admits one sample and retires the one S samples older.
  task automatic model_edge();
    logic [W-1:0] word;
    if (!en) return;
    word = (int'(sel) < N) ? W'(data >> (int'(sel) * W)) : '0;
    exp_q.push_back({in_valid, word});
    void'(exp_q.pop_front());
    if (in_valid && int'(sel) >= N) exp_err = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_y"},   32'(y),         32'(exp_q[0][W-1:0]));
    check({tag, "_ov"},  32'(out_valid), 32'(exp_q[0][W]));
    check({tag, "_err"}, 32'(sel_err),   32'(exp_err));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, let one rising edge happen, check at the next falling edge.
  task automatic step(input logic e, input logic iv, input logic [1:0] s, input logic [N*W-1:0] d,
                      input string tag);
    en = e; in_valid = iv; sel = s; data = d;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs(tag);
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    model_reset();
    #1 check_outputs(tag);
    check({tag, "_y0"}, 32'(y), 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    check("reset_lg_y", 32'(lg_y), 32'h0);
    check("reset_lg_ov", 32'(lg_out_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Legacy 2:1 behaviour: y = cond ? t : f one cycle later.
    lg_cond = 1'b0; lg_data = 2'b10;
    @(negedge clock);
    check("legacy_c0", 32'(lg_y), 32'h0);
    check("legacy_ov", 32'(lg_out_valid), 32'h1);
    lg_cond = 1'b1; lg_data = 2'b10;
    @(negedge clock);
    check("legacy_c1", 32'(lg_y), 32'h1);
    lg_cond = 1'b1; lg_data = 2'b01;
    @(negedge clock);
    check("legacy_c1b", 32'(lg_y), 32'h0);
    check("legacy_err", 32'(lg_sel_err), 32'h0);

    // Out-of-range select without in_valid must not raise sel_err.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd3, 24'h332211, "sel3_novalid");

    // In-order sweep, then a stall after the sel=1 sample.
    step(1'b1, 1'b1, 2'd0, 24'h332211, "sweep0");
    step(1'b1, 1'b1, 2'd1, 24'h332211, "sweep1");
    step(1'b0, 1'b1, 2'd2, 24'h332211, "stall0");
    step(1'b0, 1'b0, 2'd0, 24'h000000, "stall1");
    step(1'b1, 1'b1, 2'd2, 24'h332211, "sweep2");
    for (int i = 0; i < S + 1; i++) step(1'b1, 1'b0, 2'd0, 24'h0, "drain");

    // Valid pattern 1,0,1 then an out-of-range valid sample that zero-fills and sets sel_err.
    step(1'b1, 1'b1, 2'd1, 24'hA5B6C7, "vpat1");
    step(1'b1, 1'b0, 2'd2, 24'hA5B6C7, "vpat0");
    step(1'b1, 1'b1, 2'd2, 24'hA5B6C7, "vpat1b");
    step(1'b1, 1'b1, 2'd3, 24'hFFFFFF, "oor");
    for (int i = 0; i < S + 1; i++) step(1'b1, 1'b0, 2'd0, 24'h0, "oor_drain");

    // Mid-stream reset, then recovery.
    step(1'b1, 1'b1, 2'd0, 24'h123456, "pre_rst");
    async_reset("midrst");
    for (int i = 0; i < S + 1; i++) step(1'b1, (i == 0), 2'd2, 24'h9ABCDE, "post_rst");

    // Randomized phase with periodic asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      logic           e, iv;
      logic [1:0]     s;
      logic [N*W-1:0] d;
      e  = ($urandom_range(0, 3) != 0);
      iv = $urandom_range(0, 1) == 1;
      s  = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      d  = N*W'($urandom);
      step(e, iv, s, d, "rand");
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
